clz_seq_unit: RTL

Multi-cycle count-leading-zeros / count-leading-ones sequencer for the EX stage of the static pipeline. It accepts one operand per request, scans it STEP bits per cycle from the MSB down, and returns a 32-bit count with a one-cycle done pulse. It drives a stall request into the hazard unit while a scan is in flight, and honours pipeline flushes. It serves both the CLZ and CLO instructions.

---
 rtl/clz_seq_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/clz_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : clz_seq_unit
//  Description : Multi-cycle count-leading-zeros / count-leading-ones unit
//                for the EX stage. Scans the operand STEP bits per cycle from
//                the MSB down, returns a 32-bit count with a one-cycle done
//                pulse, stalls the pipeline while a scan is in flight and
//                aborts on a pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module clz_seq_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_clo,
  input  logic [WIDTH-1:0] data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             stall
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int c_NUM_CHUNKS = WIDTH / STEP;
  // Running count must hold WIDTH itself, hence log2(WIDTH)+1 bits.
  localparam int c_CNT_W      = $clog2(WIDTH) + 1;
  localparam int c_CHUNK_W    = (c_NUM_CHUNKS > 1) ? $clog2(c_NUM_CHUNKS) : 1;
  // In-chunk leading-zero count ranges 0..STEP.
  localparam int c_LZ_W       = $clog2(STEP) + 1;

  localparam logic [c_CHUNK_W-1:0] c_LAST_CHUNK = c_CHUNK_W'(c_NUM_CHUNKS - 1);
  localparam logic [c_CNT_W-1:0]   c_STEP_CNT   = c_CNT_W'(STEP);
  localparam logic [31:0]          c_FULL_COUNT = 32'(WIDTH);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_op;      // operand, shifted left one chunk per scan cycle
  logic [c_CNT_W-1:0]   r_cnt;     // zeros counted in chunks already passed
  logic [c_CHUNK_W-1:0] r_chunk;   // index of the chunk now at the top of r_op
  logic [31:0]          r_result;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [STEP-1:0]    w_top;
  logic               w_top_zero;
  logic               w_last;
  logic [c_LZ_W-1:0]  w_lz;
  logic [WIDTH-1:0]   w_op_in;
  logic               w_accept;
  logic [31:0]        w_hit_count;

  // CLO reuses the CLZ datapath on the inverted operand.
  assign w_op_in    = is_clo ? ~data : data;
  assign w_top      = r_op[WIDTH-1 -: STEP];
  assign w_top_zero = (w_top == '0);
  assign w_last     = (r_chunk == c_LAST_CHUNK);
  // A start is taken in IDLE or DONE only; flush always wins over start.
  assign w_accept   = start & ~flush & (r_state != c_SCAN);

  // Priority encode the top chunk: the highest set bit defines the in-chunk count.
  always_comb begin
    w_lz = c_LZ_W'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (w_top[i]) begin
        w_lz = c_LZ_W'(STEP - 1 - i);
      end
    end
  end

  assign w_hit_count = 32'(r_cnt) + 32'(w_lz);

  // --------------------------------------------------------------------------
  // Sequencer: IDLE -> SCAN (one chunk per cycle) -> DONE
  // --------------------------------------------------------------------------
  // State, operand, running count and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_chunk  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op    <= w_op_in;
            r_cnt   <= '0;
            r_chunk <= '0;
            r_state <= c_SCAN;
          end
        end

        c_SCAN: begin
          if (flush) begin
            // Abandon the scan; result keeps the last completed value.
            r_state <= c_IDLE;
          end else if (w_top_zero) begin
            if (w_last) begin
              r_result <= c_FULL_COUNT;
              r_state  <= c_DONE;
            end else begin
              r_cnt   <= r_cnt + c_STEP_CNT;
              r_op    <= r_op << STEP;
              r_chunk <= r_chunk + 1'b1;
            end
          end else begin
            r_result <= w_hit_count;
            r_state  <= c_DONE;
          end
        end

        c_DONE: begin
          // Back-to-back requests are accepted straight out of DONE.
          if (w_accept) begin
            r_op    <= w_op_in;
            r_cnt   <= '0;
            r_chunk <= '0;
            r_state <= c_SCAN;
          end else begin
            r_state <= c_IDLE;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy   = (r_state == c_SCAN);
  assign done   = (r_state == c_DONE);
  assign result = r_result;
  // Stall while scanning and in the cycle a new request is accepted; DONE
  // without a new start leaves stall low so the pipeline captures result.
  assign stall  = ~rst & (w_accept | (r_state == c_SCAN));

endmodule
`default_nettype wire
